// File: rtl/cpu_pkg.sv
// Shared LEGv8 core definitions: MUL sequencer state encoding and MUL decode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam logic [2:0]  ALUOP_MUL  = 3'b111;
    localparam logic [10:0] OPCODE_MUL = 11'b10011011000;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier datapath: acc/mcand/mplier/cnt registers driven by load/step.
// Latency: one step per cycle; acc_step and last_step preview the current step combinationally.
// Backpressure: none; the controller decides when load/step fire. MUL_EARLY_EXIT_EN enables mplier_zero.
module mul_shift_add
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_step,
    output logic             mplier_zero,
    output logic             last_step
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;

    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        cnt_inc  = cnt_q + CW'(1);
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_inc;
        end
    end

    assign acc       = acc_q;
    assign last_step = (cnt_inc == CW'(WIDTH));

`ifdef MUL_EARLY_EXIT_EN
    assign mplier_zero = (mplier_q == '0);
`else
    assign mplier_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative MUL controller: stalls the front end while mul_shift_add iterates, then requests write-back.
// Latency: WIDTH+1 cycles start-to-done (shorter with MUL_EARLY_EXIT_EN when op_b has leading zeros).
// Backpressure: stall holds PC/IR through the start cycle and RUN; start outside IDLE is ignored.
module mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [REGADDR-1:0] rd_in,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic               wr_en,
    output logic [REGADDR-1:0] rd_out,
    output logic [WIDTH-1:0]   result
);

    mul_state_t         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [REGADDR-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]   acc, acc_step;
    logic               load, step, last_step;
`ifdef MUL_EARLY_EXIT_EN
    logic               mplier_zero;
`else
    logic               unused_mplier_zero;
`endif

    mul_shift_add #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .op_a        (op_a),
        .op_b        (op_b),
        .acc         (acc),
        .acc_step    (acc_step),
`ifdef MUL_EARLY_EXIT_EN
        .mplier_zero (mplier_zero),
`else
        .mplier_zero (unused_mplier_zero),
`endif
        .last_step   (last_step)
    );

    // result is captured on entry to DONE so it is already valid in the done cycle.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    rd_d    = rd_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
`ifdef MUL_EARLY_EXIT_EN
                end else if (mplier_zero) begin
                    result_d = acc;
                    state_d  = DONE;
`endif
                end else begin
                    step = 1'b1;
                    if (last_step) begin
                        result_d = acc_step;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall  = ((state_q == IDLE) && start && !abort) || (state_q == RUN);
        busy   = (state_q != IDLE);
        done   = (state_q == DONE) && !abort;
        wr_en  = done;
        rd_out = rd_q;
        result = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiplier controller for the single-cycle LEGv8 core. It replaces the combinational 64×64 multiply path for MUL (ALUOp 3'b111). The decode stage raises `start` with both operands. The block stalls the front end while it iterates, then delivers the low 64 bits of the product with a one-cycle register write-back request. It sits beside the ALU and feeds the write-back mux.

## Interface
- `WIDTH`, default 64: operand and result width; must be ≥ 2.
- `REGADDR`, default 5: destination register index width.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: MUL decoded this cycle; sampled only in IDLE.
- `abort`, input, 1: flush request; cancels any operation in progress.
- `op_a`, input, WIDTH: multiplicand (Rn value).
- `op_b`, input, WIDTH: multiplier (Rm value).
- `rd_in`, input, REGADDR: destination register.
- `stall`, output, 1: holds PC and the instruction register.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle result-valid pulse.
- `wr_en`, output, 1: register-file write enable; equals `done`.
- `rd_out`, output, REGADDR: latched destination register.
- `result`, output, WIDTH: product bits [WIDTH-1:0].

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- **IDLE:**
  - On `start && !abort`, latch `mcand=op_a`, `mplier=op_b`, `rd=rd_in`, `acc=0`, `cnt=0`, then go to RUN.
  - Otherwise stay in IDLE.
- **RUN, each cycle:**
  - If `mplier[0]`, set `acc = acc + mcand` (mod 2^WIDTH).
  - Then `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - When the updated `cnt == WIDTH`, go to DONE.
- **DONE:** `result = acc`, `done = wr_en = 1`, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored; the instruction is still held by `stall`.
- `abort` in any state forces IDLE next cycle. `done` is not raised and `acc` is discarded.
- `abort` has priority over `start` and over the DONE transition. An abort during DONE still suppresses `wr_en` that cycle (combinational gating).
- Arithmetic:
  - Product bits above WIDTH-1 are dropped; no flags.
  - Operands are unsigned; the low half is identical for signed operands.
  - `cnt` is `$clog2(WIDTH)+1` bits wide, so it never wraps before reaching WIDTH.
- `stall = (state==IDLE && start && !abort) || state==RUN`. It is combinational and low in DONE, so the MUL retires that cycle.
- `result` and `rd_out` are registered. They hold their value after DONE until the next latch.
- **Reset values:** state IDLE; `acc`, `mcand`, `mplier`, `cnt`, `rd`, `result` = 0; `stall`, `busy`, `done`, `wr_en` = 0.
- Reset asserted mid-RUN returns to IDLE on that edge with no `done`.

## Timing
- With `start` sampled at edge N: RUN occupies cycles N+1 … N+WIDTH, and `done` is high during cycle N+WIDTH+1.
- Latency is WIDTH+1 cycles. `stall` is high for WIDTH+1 cycles, starting in the `start` cycle.
- The earliest next `start` acceptance is the first IDLE cycle after DONE, i.e. back-to-back MULs with one gap cycle (the DONE cycle).
- No combinational path exists from `op_a`/`op_b` to any output.

## Configuration
- `MUL_EARLY_EXIT_EN`
  - **Defined:** in RUN, if `mplier == 0` at the start of the cycle, skip the update and go to DONE. Latency becomes 1 + (index of the highest set bit of `op_b` + 1) + 1 cycles; for `op_b=0`, `done` is at N+2.
  - **Undefined:** fixed WIDTH+1 latency, and `mplier` is not compared.
- `result` is identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - the `mul_state_t` enum {IDLE, RUN, DONE};
  - the `ALUOP_MUL = 3'b111` constant;
  - the MUL opcode constant `11'b10011011000`.
- A natural sub-module is `mul_shift_add`, the datapath registers (`acc`, `mcand`, `mplier`, `cnt`) with `load`/`step` controls.
- The FSM, `stall`, and `done` gating stay in `mul_sequencer`.

## Test plan
- Reset, then `start` with `op_a=3`, `op_b=5`, `rd_in=9` at edge N → `done`/`wr_en` only in cycle N+65; `result=15`; `rd_out=9`; `stall` high exactly 65 cycles.
- `op_a=64'hFFFF_FFFF_FFFF_FFFF`, `op_b=2` → `result=64'hFFFF_FFFF_FFFF_FFFE` (truncation).
- `start` pulsed again mid-RUN with different operands → ignored; the original product is delivered; the next `start` in IDLE is accepted.
- `abort` at cycle N+20 → IDLE at N+21; `done` and `wr_en` never assert; `stall` low from N+21.
- `reset` at cycle N+30 → all outputs 0 next cycle; a fresh `7*6` then yields 42.
- With `MUL_EARLY_EXIT_EN`:
  - `op_b=0` → `done` at N+2, `result=0`;
  - `op_b=1`, `op_a=0x1234` → `done` at N+3, `result=0x1234`;
  - without the macro, both cases finish at N+65.
